seven_segment_scan: RTL and testbench

Parametrised multiplexed N-digit seven-segment display driver with hex decode, per-digit decimal point, blanking and blink.
- Scans one digit per dwell period and presents registered anode and segment drives to board pins.
- New display content arrives over a valid/ready load port and is double-buffered, so it takes effect only at a frame boundary (no tearing).
- Sits between the cipher status/output logic and the board display pins.

---
 rtl/seven_seg_pkg.sv | 33 +++
 rtl/hex_to_seg.sv | 36 +++
 rtl/seven_segment_scan.sv | 158 +++++++++++++++
 tb/tb_seven_segment_scan.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display driver.
//   - Segment bit positions inside a 7-bit code {g,f,e,d,c,b,a}.
//   - Active-high segment codes for the 16 hex digits.
package seven_seg_pkg;

    // Bit positions of each segment inside the 7-bit code.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high codes, bit order gfedcba.
    localparam logic [6:0] SEG_HEX_0 = 7'b0111111;
    localparam logic [6:0] SEG_HEX_1 = 7'b0000110;
    localparam logic [6:0] SEG_HEX_2 = 7'b1011011;
    localparam logic [6:0] SEG_HEX_3 = 7'b1001111;
    localparam logic [6:0] SEG_HEX_4 = 7'b1100110;
    localparam logic [6:0] SEG_HEX_5 = 7'b1101101;
    localparam logic [6:0] SEG_HEX_6 = 7'b1111101;
    localparam logic [6:0] SEG_HEX_7 = 7'b0000111;
    localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
    localparam logic [6:0] SEG_HEX_9 = 7'b1101111;
    localparam logic [6:0] SEG_HEX_A = 7'b1110111;
    localparam logic [6:0] SEG_HEX_B = 7'b1111100;
    localparam logic [6:0] SEG_HEX_C = 7'b0111001;
    localparam logic [6:0] SEG_HEX_D = 7'b1011110;
    localparam logic [6:0] SEG_HEX_E = 7'b1111001;
    localparam logic [6:0] SEG_HEX_F = 7'b1110001;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to seven-segment decoder.
// Ports:
//   nibble  in  4  hex value 0..F
//   code    out 7  active-high segment code {g,f,e,d,c,b,a}
// Output polarity is applied by the instantiating module.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] code
);

    always_comb begin
        code = SEG_HEX_0;
        case (nibble)
            4'h0: code = SEG_HEX_0;
            4'h1: code = SEG_HEX_1;
            4'h2: code = SEG_HEX_2;
            4'h3: code = SEG_HEX_3;
            4'h4: code = SEG_HEX_4;
            4'h5: code = SEG_HEX_5;
            4'h6: code = SEG_HEX_6;
            4'h7: code = SEG_HEX_7;
            4'h8: code = SEG_HEX_8;
            4'h9: code = SEG_HEX_9;
            4'hA: code = SEG_HEX_A;
            4'hB: code = SEG_HEX_B;
            4'hC: code = SEG_HEX_C;
            4'hD: code = SEG_HEX_D;
            4'hE: code = SEG_HEX_E;
            4'hF: code = SEG_HEX_F;
            default: code = SEG_HEX_0;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed N-digit seven-segment display driver.
// Scans one digit per dwell period, with a dark gap at the start of each
// dwell, hex decode, per-digit decimal point, blanking and blinking.
// New frames arrive on a valid/ready port into a pending buffer and are
// copied to the active frame only when the scan wraps back to digit 0.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   enable      1 = display on; 0 = all anodes off, scan keeps running
//   load_valid  new frame offered
//   load_ready  pending buffer empty
//   load_data   nibble per digit, digit 0 in bits [3:0]
//   load_dp     decimal point per digit
//   load_blank  1 = digit dark
//   load_blink  1 = digit blinks
//   anode       one-hot digit select (registered, polarity per ACTIVE_LOW)
//   seg         segments {g,f,e,d,c,b,a} (registered)
//   dp          decimal point (registered)
//   frame_done  one-cycle pulse when the scan wraps to digit 0
module seven_segment_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 65536,
    parameter int BLANK_CYCLES = 256,
    parameter int BLINK_BITS   = 25,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic [NUM_DIGITS-1:0]   load_blank,
    input  logic [NUM_DIGITS-1:0]   load_blink,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
    localparam logic [DW-1:0] BLANK_END  = DW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // XOR masks that turn active-high drive into pin polarity.
    localparam logic                  POL    = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_POL = {NUM_DIGITS{POL}};
    localparam logic [6:0]            SG_POL = {7{POL}};

    logic [DW-1:0]           dwell_reg;
    logic [IW-1:0]           idx_reg;
    logic [BLINK_BITS-1:0]   blink_cnt_reg;

    logic [4*NUM_DIGITS-1:0] act_data_reg,  pend_data_reg;
    logic [NUM_DIGITS-1:0]   act_dp_reg,    pend_dp_reg;
    logic [NUM_DIGITS-1:0]   act_blank_reg, pend_blank_reg;
    logic [NUM_DIGITS-1:0]   act_blink_reg, pend_blink_reg;
    logic                    pend_full_reg;

    logic [NUM_DIGITS-1:0]   anode_reg;
    logic [6:0]              seg_reg;
    logic                    dp_reg;
    logic                    frame_done_reg;

    logic                    dwell_wrap;
    logic                    frame_wrap;
    logic                    load_fire;
    logic                    blink_phase;
    logic                    digit_lit;
    logic [3:0]              cur_nibble;
    logic [6:0]              cur_code;
    logic [NUM_DIGITS-1:0]   onehot;
    logic [3:0]              digit_nibble [NUM_DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign onehot[gi]       = (idx_reg == IW'(gi));
            assign digit_nibble[gi] = act_data_reg[gi*4 +: 4];
        end
    endgenerate

    assign dwell_wrap  = (dwell_reg == DWELL_LAST);
    assign frame_wrap  = dwell_wrap && (idx_reg == IDX_LAST);
    assign load_fire   = load_valid && !pend_full_reg;
    assign blink_phase = blink_cnt_reg[BLINK_BITS-1];
    assign cur_nibble  = digit_nibble[idx_reg];

    assign digit_lit = enable && (dwell_reg >= BLANK_END)
                       && !act_blank_reg[idx_reg]
                       && !(act_blink_reg[idx_reg] && blink_phase);

    hex_to_seg u_hex_to_seg (
        .nibble (cur_nibble),
        .code   (cur_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_reg      <= '0;
            idx_reg        <= '0;
            blink_cnt_reg  <= '0;
            act_data_reg   <= '0;
            act_dp_reg     <= '0;
            act_blank_reg  <= '1;
            act_blink_reg  <= '0;
            pend_data_reg  <= '0;
            pend_dp_reg    <= '0;
            pend_blank_reg <= '0;
            pend_blink_reg <= '0;
            pend_full_reg  <= 1'b0;
            anode_reg      <= AN_POL;
            seg_reg        <= SG_POL;
            dp_reg         <= POL;
            frame_done_reg <= 1'b0;
        end else begin
            dwell_reg     <= dwell_wrap ? '0 : dwell_reg + 1'b1;
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
            if (dwell_wrap) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end
            frame_done_reg <= frame_wrap;

            // Commit uses the pending state from before this edge, so a load
            // accepted on the wrap cycle waits for the following wrap.
            if (frame_wrap && pend_full_reg) begin
                act_data_reg  <= pend_data_reg;
                act_dp_reg    <= pend_dp_reg;
                act_blank_reg <= pend_blank_reg;
                act_blink_reg <= pend_blink_reg;
            end
            if (load_fire) begin
                pend_data_reg  <= load_data;
                pend_dp_reg    <= load_dp;
                pend_blank_reg <= load_blank;
                pend_blink_reg <= load_blink;
                pend_full_reg  <= 1'b1;
            end else if (frame_wrap) begin
                pend_full_reg <= 1'b0;
            end

            anode_reg <= (digit_lit ? onehot : '0) ^ AN_POL;
            seg_reg   <= (digit_lit ? cur_code : 7'b0) ^ SG_POL;
            dp_reg    <= (digit_lit && act_dp_reg[idx_reg]) ^ POL;
        end
    end

    assign load_ready = !pend_full_reg;
    assign anode      = anode_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_segment_scan.sv
module tb_seven_segment_scan;

    localparam int N     = 4;
    localparam int DWELL = 4;
    localparam int BLANK = 1;
    localparam int BB    = 4;
    localparam int FRAME = N * DWELL;

    // Active-high hex codes, gfedcba.
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            load_valid;
    logic            load_ready;
    logic [4*N-1:0]  load_data;
    logic [N-1:0]    load_dp;
    logic [N-1:0]    load_blank;
    logic [N-1:0]    load_blink;
    logic [N-1:0]    anode;
    logic [6:0]      seg;
    logic            dp;
    logic            frame_done;

    always #5 clk = ~clk;

    seven_segment_scan #(
        .NUM_DIGITS   (N),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK),
        .BLINK_BITS   (BB),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_dp    (load_dp),
        .load_blank (load_blank),
        .load_blink (load_blink),
        .anode      (anode),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: time since reset plus the two frame buffers.
    int             m_t;
    logic           m_full;
    logic [4*N-1:0] m_act_data, m_pen_data;
    logic [N-1:0]   m_act_dp, m_pen_dp, m_act_blank, m_pen_blank, m_act_blink, m_pen_blink;
    logic [N-1:0]   e_anode;
    logic [6:0]     e_seg;
    logic           e_dp, e_fd;
    bit             last_xfer;

    typedef struct {
        logic [3:0] nib;
        logic       dpin;
        logic [6:0] exp_seg;
        logic       exp_dp;
    } vec_t;
    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h expected=%0h", name, m_t, got, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_full = 0;
        m_act_data = '0; m_act_dp = '0; m_act_blank = '1; m_act_blink = '0;
        m_pen_data = '0; m_pen_dp = '0; m_pen_blank = '0; m_pen_blink = '0;
        e_anode = '1; e_seg = '1; e_dp = 1'b1; e_fd = 1'b0;
    endtask

    // One clock cycle: compare pins with the model, then advance the model.
    task automatic tick();
        int   d, ix;
        bit   ph, lit, commit, xfer;
        logic [3:0] nib;
        @(negedge clk);
        checks++;
        if (anode !== e_anode || seg !== e_seg || dp !== e_dp || frame_done !== e_fd
            || load_ready !== !m_full) begin
            errors++;
            $display("FAIL pins t=%0d got anode=%b seg=%b dp=%b fd=%b rdy=%b expected anode=%b seg=%b dp=%b fd=%b rdy=%b",
                     m_t, anode, seg, dp, frame_done, load_ready, e_anode, e_seg, e_dp, e_fd, !m_full);
        end
        xfer = 0;
        if (rst) begin
            model_reset();
        end else begin
            d   = m_t % DWELL;
            ix  = (m_t / DWELL) % N;
            ph  = (m_t % (1 << BB)) >= (1 << (BB - 1));
            lit = enable && (d >= BLANK) && !m_act_blank[ix] && !(m_act_blink[ix] && ph);
            nib = m_act_data[ix*4 +: 4];
            e_anode = lit ? ~(4'b0001 << ix) : 4'hF;
            e_seg   = lit ? ~SEG_TAB[nib] : 7'h7F;
            e_dp    = lit ? ~m_act_dp[ix] : 1'b1;
            e_fd    = ((m_t + 1) % FRAME) == 0;
            commit  = ((m_t % FRAME) == FRAME - 1) && m_full;
            xfer    = load_valid && !m_full;
            if (commit) begin
                m_act_data = m_pen_data; m_act_dp = m_pen_dp;
                m_act_blank = m_pen_blank; m_act_blink = m_pen_blink;
                m_full = 0;
            end
            if (xfer) begin
                m_pen_data = load_data; m_pen_dp = load_dp;
                m_pen_blank = load_blank; m_pen_blink = load_blink;
                m_full = 1;
            end
            m_t++;
        end
        last_xfer = xfer;
        @(posedge clk);
        #1;
    endtask

    // Advance at least one cycle, stopping when the current cycle is p mod FRAME.
    task automatic wait_phase(input int p);
        int k = 0;
        do begin
            tick();
            k++;
        end while ((m_t % FRAME) != p && k < 64);
        if (k >= 64) chk("wait_phase_timeout", 0, 1);
    endtask

    task automatic wait_commit();
        int k = 0;
        while (m_full && k < 64) begin
            tick();
            k++;
        end
        if (k >= 64) chk("commit_timeout", 0, 1);
    endtask

    task automatic load_frame(input logic [4*N-1:0] d, input logic [N-1:0] dpv,
                              input logic [N-1:0] bl, input logic [N-1:0] bk);
        bit ok = 0;
        load_data = d; load_dp = dpv; load_blank = bl; load_blink = bk;
        load_valid = 1'b1;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (last_xfer) begin ok = 1; break; end
        end
        load_valid = 1'b0;
        if (!ok) chk("load_accept_timeout", 0, 1);
    endtask

    initial begin
        int   fd_at, fd_cnt, lit_cnt, acc_t;
        bit   ok;

        vecs[0]  = '{4'h0, 1'b0, 7'b1000000, 1'b1};
        vecs[1]  = '{4'h1, 1'b1, 7'b1111001, 1'b0};
        vecs[2]  = '{4'h2, 1'b0, 7'b0100100, 1'b1};
        vecs[3]  = '{4'h3, 1'b1, 7'b0110000, 1'b0};
        vecs[4]  = '{4'h4, 1'b0, 7'b0011001, 1'b1};
        vecs[5]  = '{4'h5, 1'b1, 7'b0010010, 1'b0};
        vecs[6]  = '{4'h6, 1'b0, 7'b0000010, 1'b1};
        vecs[7]  = '{4'h7, 1'b1, 7'b1111000, 1'b0};
        vecs[8]  = '{4'h8, 1'b0, 7'b0000000, 1'b1};
        vecs[9]  = '{4'h9, 1'b1, 7'b0010000, 1'b0};
        vecs[10] = '{4'hA, 1'b0, 7'b0001000, 1'b1};
        vecs[11] = '{4'hB, 1'b1, 7'b0000011, 1'b0};
        vecs[12] = '{4'hC, 1'b0, 7'b1000110, 1'b1};
        vecs[13] = '{4'hD, 1'b1, 7'b0100001, 1'b0};
        vecs[14] = '{4'hE, 1'b0, 7'b0000110, 1'b1};
        vecs[15] = '{4'hF, 1'b1, 7'b0001110, 1'b0};

        rst = 1'b1; enable = 1'b0; load_valid = 1'b0;
        load_data = '0; load_dp = '0; load_blank = '0; load_blink = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        enable = 1'b1;

        // Reset state.
        chk("reset_anode", anode, 4'hF);
        chk("reset_seg", seg, 7'h7F);
        chk("reset_dp", dp, 1);
        chk("reset_ready", load_ready, 1);
        chk("reset_fd", frame_done, 0);

        // First frame_done one full frame after reset release.
        fd_at = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (frame_done === 1'b1) begin fd_at = m_t; break; end
        end
        chk("first_frame_done", fd_at, FRAME);

        // Reference frame 0x8A10, dp on digit 0.
        load_frame(16'h8A10, 4'b0001, 4'b0000, 4'b0000);
        wait_commit();
        wait_phase(1);
        chk("gap_anode", anode, 4'b1111);
        wait_phase(3);
        chk("d0_anode", anode, 4'b1110);
        chk("d0_seg", seg, 7'b1000000);
        chk("d0_dp", dp, 0);
        wait_phase(15);
        chk("d3_anode", anode, 4'b0111);
        chk("d3_seg", seg, 7'b0000000);
        chk("d3_dp", dp, 1);

        // Table-driven decode of every nibble on digit 0.
        for (int i = 0; i < 16; i++) begin
            load_frame({4{vecs[i].nib}}, {3'b000, vecs[i].dpin}, 4'b0000, 4'b0000);
            wait_commit();
            wait_phase(3);
            chk("tab_anode", anode, 4'b1110);
            chk("tab_seg", seg, vecs[i].exp_seg);
            chk("tab_dp", dp, vecs[i].exp_dp);
        end

        // Back-to-back loads: second held until one cycle after the commit.
        load_data = 16'h1111; load_dp = '0; load_blank = '0; load_blink = '0;
        load_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (last_xfer) begin ok = 1; break; end
        end
        chk("b2b_first_accept", ok, 1);
        chk("b2b_ready_low", load_ready, 0);
        load_data = 16'h2222;
        ok = 0; acc_t = -1;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (last_xfer) begin ok = 1; acc_t = m_t - 1; break; end
        end
        load_valid = 1'b0;
        chk("b2b_second_accept", ok, 1);
        chk("b2b_accept_phase", acc_t % FRAME, 0);
        wait_phase(3);
        chk("b2b_old_shown", seg, 7'b1111001);
        wait_phase(3);
        chk("b2b_new_shown", seg, 7'b0100100);

        // Load on the exact wrap cycle.
        wait_commit();
        wait_phase(FRAME - 1);
        load_data = 16'h3333; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("wrap_load_accept", last_xfer, 1);
        wait_phase(3);
        chk("wrap_old_frame", seg, 7'b0100100);
        wait_phase(3);
        chk("wrap_new_frame", seg, 7'b0110000);

        // Blink on digit 2, then blank on digit 0.
        load_frame(16'h8888, 4'b0000, 4'b0000, 4'b0100);
        wait_commit();
        wait_phase(11);
        chk("blink_d2_dark", anode, 4'b1111);
        wait_phase(15);
        chk("blink_d3_lit", anode, 4'b0111);
        load_frame(16'h8888, 4'b0000, 4'b0001, 4'b0000);
        wait_commit();
        wait_phase(3);
        chk("blank_d0_dark", anode, 4'b1111);
        wait_phase(7);
        chk("blank_d1_lit", anode, 4'b1101);

        // Display disabled: no anode, frame_done still pulses.
        enable = 1'b0;
        fd_cnt = 0; lit_cnt = 0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (frame_done === 1'b1) fd_cnt++;
            if (anode !== 4'hF) lit_cnt++;
        end
        chk("disable_fd_count", fd_cnt, 2);
        chk("disable_lit_count", lit_cnt, 0);
        enable = 1'b1;

        // Random frames and handshake timing against the model.
        for (int k = 0; k < 600; k++) begin
            if (!load_valid || last_xfer) begin
                load_valid = ($urandom % 3) == 0;
                load_data  = 16'($urandom);
                load_dp    = 4'($urandom);
                load_blank = 4'($urandom & $urandom);
                load_blink = 4'($urandom & $urandom);
            end
            enable = ($urandom % 8) != 0;
            tick();
        end
        load_valid = 1'b0;
        enable = 1'b1;
        wait_commit();

        // Reset while a frame is pending.
        load_frame(16'h5555, 4'b1111, 4'b0000, 4'b0000);
        chk("rst_pending_ready", load_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_ready", load_ready, 1);
        chk("rst_anode", anode, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        lit_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (anode !== 4'hF) lit_cnt++;
        end
        chk("rst_dark_after", lit_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog t=%0d got=timeout expected=finish", m_t);
        $fatal(1, "watchdog");
    end

endmodule
